// File: rtl/addr_decoder_cfg_loader.sv
// Framed byte-stream loader for the address decoder configuration store.
// Frames (A5, ADDR, LEN, data..., CSUM) are buffered and checksum-verified
// before being replayed as consecutive byte writes on the cfg_we port.
module addr_decoder_cfg_loader #(
    parameter int unsigned CFG_SPACE = 160,
    parameter int unsigned MAX_LEN   = 32
) (
    input  logic       cfg_clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       cfg_we,
    output logic [7:0] cfg_addr,
    output logic [7:0] cfg_wdata,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [1:0] err_code
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned IDX_W  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [BYTE_W:0]   CFG_SPACE_W = 9'(CFG_SPACE);
    localparam logic [BYTE_W-1:0] MAX_LEN_B   = 8'(MAX_LEN);
    localparam logic [BYTE_W-1:0] SYNC_BYTE   = 8'hA5;
    localparam logic [1:0] ERR_LEN   = 2'd1;
    localparam logic [1:0] ERR_RANGE = 2'd2;
    localparam logic [1:0] ERR_CSUM  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_LEN, S_DATA, S_CSUM, S_COMMIT
    } state_t;

    state_t state_q, state_nxt;

    logic [BYTE_W-1:0] addr_q, addr_nxt;
    logic [BYTE_W-1:0] len_q, len_nxt;
    logic [BYTE_W-1:0] sum_q, sum_nxt;
    logic [BYTE_W-1:0] cnt_q, cnt_nxt;

    logic              in_ready_nxt, cfg_we_nxt, busy_nxt, done_nxt, err_nxt;
    logic [BYTE_W-1:0] cfg_addr_nxt, cfg_wdata_nxt;
    logic [1:0]        err_code_nxt;

    logic              buf_we_c;
    logic [BYTE_W-1:0] pay_mem [MAX_LEN];

    logic              accept_c;
    logic [BYTE_W:0]   range_sum_c;
    logic [BYTE_W-1:0] sum_add_c;

    assign accept_c    = in_valid && in_ready;
    assign range_sum_c = {1'b0, addr_q} + {1'b0, in_data};
    assign sum_add_c   = sum_q + in_data;

    // State and datapath registers, outputs included
    always_ff @(posedge cfg_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            len_q     <= '0;
            sum_q     <= '0;
            cnt_q     <= '0;
            in_ready  <= 1'b0;
            cfg_we    <= 1'b0;
            cfg_addr  <= '0;
            cfg_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            err_code  <= '0;
        end else begin
            state_q   <= state_nxt;
            addr_q    <= addr_nxt;
            len_q     <= len_nxt;
            sum_q     <= sum_nxt;
            cnt_q     <= cnt_nxt;
            in_ready  <= in_ready_nxt;
            cfg_we    <= cfg_we_nxt;
            cfg_addr  <= cfg_addr_nxt;
            cfg_wdata <= cfg_wdata_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            err       <= err_nxt;
            err_code  <= err_code_nxt;
        end
    end

    // Payload buffer; never cleared, only indices below LEN are replayed
    always_ff @(posedge cfg_clk) begin
        if (buf_we_c) begin
            pay_mem[cnt_q[IDX_W-1:0]] <= in_data;
        end
    end

    // Frame parser, checks and commit sequencer
    always_comb begin
        state_nxt     = state_q;
        addr_nxt      = addr_q;
        len_nxt       = len_q;
        sum_nxt       = sum_q;
        cnt_nxt       = cnt_q;
        cfg_we_nxt    = 1'b0;
        cfg_addr_nxt  = cfg_addr;
        cfg_wdata_nxt = cfg_wdata;
        done_nxt      = 1'b0;
        err_nxt       = 1'b0;
        err_code_nxt  = err_code;
        buf_we_c      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept_c && in_data == SYNC_BYTE) begin
                    state_nxt = S_ADDR;
                end
            end
            S_ADDR: begin
                if (accept_c) begin
                    addr_nxt  = in_data;
                    sum_nxt   = in_data;
                    state_nxt = S_LEN;
                end
            end
            S_LEN: begin
                if (accept_c) begin
                    len_nxt = in_data;
                    sum_nxt = sum_add_c;
                    if (in_data == '0 || in_data > MAX_LEN_B) begin
                        err_nxt      = 1'b1;
                        err_code_nxt = ERR_LEN;
                        state_nxt    = S_IDLE;
                    end else if (range_sum_c > CFG_SPACE_W) begin
                        err_nxt      = 1'b1;
                        err_code_nxt = ERR_RANGE;
                        state_nxt    = S_IDLE;
                    end else begin
                        cnt_nxt   = '0;
                        state_nxt = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept_c) begin
                    buf_we_c = 1'b1;
                    sum_nxt  = sum_add_c;
                    cnt_nxt  = 8'(cnt_q + 8'd1);
                    if (8'(cnt_q + 8'd1) == len_q) begin
                        state_nxt = S_CSUM;
                    end
                end
            end
            S_CSUM: begin
                if (accept_c) begin
                    if (sum_add_c != '0) begin
                        err_nxt      = 1'b1;
                        err_code_nxt = ERR_CSUM;
                        state_nxt    = S_IDLE;
                    end else begin
                        cnt_nxt   = '0;
                        state_nxt = S_COMMIT;
                    end
                end
            end
            S_COMMIT: begin
                if (cnt_q < len_q) begin
                    cfg_we_nxt    = 1'b1;
                    cfg_addr_nxt  = 8'(addr_q + cnt_q);
                    cfg_wdata_nxt = pay_mem[cnt_q[IDX_W-1:0]];
                    cnt_nxt       = 8'(cnt_q + 8'd1);
                end else begin
                    done_nxt  = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        in_ready_nxt = (state_nxt != S_COMMIT);
        busy_nxt     = (state_nxt != S_IDLE);
    end

endmodule

// File: tb/tb_addr_decoder_cfg_loader.sv
// Randomised self-checking bench for addr_decoder_cfg_loader with a
// frame-level reference model of the byte stream.
module tb_addr_decoder_cfg_loader;

    localparam int CFG_SPACE = 160;
    localparam int MAX_LEN   = 32;
    localparam int HS_LIMIT  = 200;
    localparam int IDLE_LIMIT = 300;

    typedef logic [7:0] bq_t [$];

    logic       cfg_clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       cfg_we;
    logic [7:0] cfg_addr;
    logic [7:0] cfg_wdata;
    logic       busy;
    logic       done;
    logic       err;
    logic [1:0] err_code;

    addr_decoder_cfg_loader #(.CFG_SPACE(CFG_SPACE), .MAX_LEN(MAX_LEN)) dut (
        .cfg_clk  (cfg_clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_wdata(cfg_wdata),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .err_code (err_code)
    );

    always #5 cfg_clk = ~cfg_clk;

    int n_checks = 0;
    int n_errors = 0;

    // expected / observed activity for the current scenario
    int exp_wq[$];
    int obs_wq[$];
    int exp_done, exp_err, exp_code;
    int done_cnt, err_cnt, last_code, ir_low;
    int exp_mem [256];
    int obs_mem [256];

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Observe the write port and pulses away from the active edge
    always @(negedge cfg_clk) begin
        if (rst_n) begin
            if (cfg_we) begin
                obs_wq.push_back({16'd0, cfg_addr, cfg_wdata});
                obs_mem[cfg_addr] = int'(cfg_wdata);
            end
            if (done) done_cnt++;
            if (err) begin
                err_cnt++;
                last_code = int'(err_code);
            end
            if (!in_ready) ir_low++;
        end
    end

    function automatic void push_exp(input int a, input int d);
        exp_wq.push_back(((a & 255) << 8) | (d & 255));
        exp_mem[a & 255] = d & 255;
    endfunction

    // Reference: interpret a byte stream by the frame rules
    function automatic void model_stream(input bq_t s);
        int i = 0;
        int a, l, sum;
        while (i < s.size()) begin
            if (s[i] != 8'hA5) begin
                i++;
                continue;
            end
            i++;
            if (i >= s.size()) break;
            a = int'(s[i]); i++;
            if (i >= s.size()) break;
            l = int'(s[i]); i++;
            if (l == 0 || l > MAX_LEN) begin
                exp_err++; exp_code = 1;
                continue;
            end
            if (a + l > CFG_SPACE) begin
                exp_err++; exp_code = 2;
                continue;
            end
            if (i + l >= s.size()) break;
            sum = a + l;
            for (int j = 0; j <= l; j++) sum += int'(s[i + j]);
            if (sum % 256 != 0) begin
                exp_err++; exp_code = 3;
            end else begin
                for (int j = 0; j < l; j++) push_exp(a + j, int'(s[i + j]));
                exp_done++;
            end
            i += l + 1;
        end
    endfunction

    function automatic bq_t make_frame(input int a, input bq_t d, input bit corrupt);
        bq_t f;
        int sum = a + d.size();
        f.push_back(8'hA5);
        f.push_back(8'(a));
        f.push_back(8'(d.size()));
        foreach (d[j]) begin
            f.push_back(d[j]);
            sum += int'(d[j]);
        end
        f.push_back(8'((256 - (sum % 256)) % 256 + (corrupt ? 1 + $urandom_range(0, 200) : 0)));
        return f;
    endfunction

    function automatic bq_t rand_data(input int n);
        bq_t d;
        for (int j = 0; j < n; j++) d.push_back(8'($urandom));
        return d;
    endfunction

    // Phase: called and returns #1 after a rising edge
    task automatic send_byte(input logic [7:0] b);
        int g = $urandom_range(0, 1) ? 0 : $urandom_range(1, 3);
        int t = 0;
        logic hs;
        repeat (g) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            @(posedge cfg_clk); #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        forever begin
            hs = in_ready;
            @(posedge cfg_clk); #1;
            if (hs) break;
            t++;
            if (t > HS_LIMIT) begin
                check("hs_timeout", t, HS_LIMIT);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic send_stream(input bq_t s);
        model_stream(s);
        foreach (s[j]) send_byte(s[j]);
    endtask

    task automatic wait_idle();
        int t = 0;
        while (!(busy == 1'b0 && in_ready == 1'b1 && cfg_we == 1'b0) && t < IDLE_LIMIT) begin
            @(posedge cfg_clk); #1;
            t++;
        end
        check("idle_wait", int'(t < IDLE_LIMIT), 1);
        repeat (2) @(posedge cfg_clk);
        #1;
    endtask

    task automatic clear_scn();
        exp_wq.delete();
        obs_wq.delete();
        exp_done = 0; exp_err = 0; exp_code = 0;
        done_cnt = 0; err_cnt = 0; last_code = 0; ir_low = 0;
    endtask

    task automatic score(input string tag);
        wait_idle();
        check({tag, "_wr_n"}, obs_wq.size(), exp_wq.size());
        foreach (exp_wq[j]) begin
            if (j < obs_wq.size()) check({tag, "_wr"}, obs_wq[j], exp_wq[j]);
        end
        check({tag, "_done_n"}, done_cnt, exp_done);
        check({tag, "_err_n"}, err_cnt, exp_err);
        if (exp_err > 0) check({tag, "_err_code"}, last_code, exp_code);
    endtask

    initial begin
        bq_t s, d;
        int a, l, kind, bad;
        for (int k = 0; k < 256; k++) begin
            exp_mem[k] = 0;
            obs_mem[k] = 0;
        end
        clear_scn();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(posedge cfg_clk);
        #1;
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_cfg_we", int'(cfg_we), 0);
        check("rst_cfg_addr", int'(cfg_addr), 0);
        check("rst_cfg_wdata", int'(cfg_wdata), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        check("rst_err_code", int'(err_code), 0);
        rst_n = 1'b1;
        @(posedge cfg_clk); #1;
        check("ready_after_rst", int'(in_ready), 1);

        // Good 3-byte frame at 0x10
        clear_scn();
        d = '{8'h11, 8'h22, 8'h33};
        send_stream(make_frame(16, d, 1'b0));
        score("good3");
        check("good3_ready_low", ir_low, 4);

        // Bad checksum
        clear_scn();
        s = '{8'hA5, 8'h10, 8'h01, 8'hAA, 8'h00};
        send_stream(s);
        score("badcsum");
        check("badcsum_busy", int'(busy), 0);

        // Length, range and top-of-space frames
        clear_scn();
        s = '{8'hA5, 8'h00, 8'h00};
        send_stream(s);
        score("len0");
        clear_scn();
        s = '{8'hA5, 8'h9E, 8'h03};
        send_stream(s);
        score("range");
        clear_scn();
        send_stream(make_frame(157, rand_data(3), 1'b0));
        score("top");
        clear_scn();
        s = '{8'hA5, 8'h00, 8'h21};
        send_stream(s);
        score("len33");

        // Noise then good frame
        clear_scn();
        s = '{8'h00, 8'hFF, 8'h5A};
        send_stream(s);
        send_stream(make_frame(40, rand_data(5), 1'b0));
        score("resync");

        // Max-length frame to 0
        clear_scn();
        send_stream(make_frame(0, rand_data(MAX_LEN), 1'b0));
        score("maxlen");

        // Reset after the second write of an 8-byte commit
        clear_scn();
        d = rand_data(8);
        s = make_frame(80, d, 1'b0);
        foreach (s[j]) send_byte(s[j]);
        push_exp(80, int'(d[0]));
        push_exp(81, int'(d[1]));
        @(posedge cfg_clk); #1;
        @(posedge cfg_clk); #1;
        @(negedge cfg_clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst_cfg_we", int'(cfg_we), 0);
        check("midrst_in_ready", int'(in_ready), 0);
        check("midrst_busy", int'(busy), 0);
        @(posedge cfg_clk); #1;
        rst_n = 1'b1;
        @(posedge cfg_clk); #1;
        score("midrst");
        clear_scn();
        send_stream(make_frame(100, rand_data(6), 1'b0));
        score("after_rst");

        // Random mix of good and rejected frames with noise
        for (int n = 0; n < 30; n++) begin
            clear_scn();
            s.delete();
            for (int j = $urandom_range(0, 3); j > 0; j--) begin
                logic [7:0] nb = 8'($urandom);
                if (nb == 8'hA5) nb = 8'h00;
                s.push_back(nb);
            end
            kind = $urandom_range(0, 3);
            case (kind)
                0, 1: begin
                    l = $urandom_range(1, MAX_LEN);
                    a = $urandom_range(0, CFG_SPACE - l);
                    d = rand_data(l);
                    s = {s, make_frame(a, d, kind == 1)};
                end
                2: begin
                    l = $urandom_range(0, 1) ? 0 : $urandom_range(MAX_LEN + 1, 255);
                    a = $urandom_range(0, 255);
                    s = {s, 8'hA5, 8'(a), 8'(l)};
                end
                default: begin
                    l = $urandom_range(1, MAX_LEN);
                    a = $urandom_range(CFG_SPACE + 1 - l, 255);
                    s = {s, 8'hA5, 8'(a), 8'(l)};
                end
            endcase
            send_stream(s);
            score("rand");
        end

        bad = 0;
        for (int k = 0; k < 256; k++) begin
            if (obs_mem[k] != exp_mem[k]) bad++;
        end
        check("store_image", bad, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
